// File: rtl/gate_bist.sv
// rtl/gate_bist.sv - BIST driver for a two-input gate: walks {A,B} through 00..11, samples Y after a settle time, scores it.
module gate_bist #(
  parameter logic [3:0] EXP    = 4'b1110,
  parameter int         SETTLE = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       Y,
  output logic       A,
  output logic       B,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [3:0] FAIL_VEC,
  output logic [2:0] ERR_CNT
);

  localparam logic [7:0] SC_LAST = 8'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  vi;
  logic [7:0]  sc;
  logic [1:0]  ab_q;
  logic [3:0]  fail_vec_q;
  logic [2:0]  err_cnt_q;
  logic        launch;
  logic        sample;
  logic        mismatch;

  // START is only honoured outside a run; a mid-run pulse is dropped.
  assign launch   = (state != RUN) && START;
  assign sample   = (state == RUN) && (sc == SC_LAST);
  // Case inequality so an X/Z on Y scores as a failure in simulation.
  assign mismatch = (Y !== EXP[vi]);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (START) state_nxt = RUN;
      RUN:     if (sample && (vi == 2'd3)) state_nxt = FIN;
      FIN:     if (START) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      vi         <= 2'd0;
      sc         <= 8'd0;
      ab_q       <= 2'b00;
      fail_vec_q <= 4'b0000;
      err_cnt_q  <= 3'd0;
    end else if (launch) begin
      vi         <= 2'd0;
      sc         <= 8'd0;
      ab_q       <= 2'b00;
      fail_vec_q <= 4'b0000;
      err_cnt_q  <= 3'd0;
    end else if (state == RUN) begin
      if (sample) begin
        sc <= 8'd0;
        vi <= vi + 2'd1;
        // The last vector returns the gate inputs to 00 as the run closes.
        ab_q <= (vi == 2'd3) ? 2'b00 : (vi + 2'd1);
        if (mismatch) begin
          fail_vec_q[vi] <= 1'b1;
          if (err_cnt_q != 3'd4) err_cnt_q <= err_cnt_q + 3'd1;
        end
      end else begin
        sc <= sc + 8'd1;
      end
    end
  end

  always_comb begin
    A        = ab_q[1];
    B        = ab_q[0];
    BUSY     = (state == RUN);
    DONE     = (state == FIN);
    PASS     = (state == FIN) && (fail_vec_q == 4'b0000);
    FAIL_VEC = fail_vec_q;
    ERR_CNT  = err_cnt_q;
  end

endmodule

// File: tb/tb_gate_bist.sv
// tb/tb_gate_bist.sv - self-checking bench for gate_bist with SETTLE=1 and SETTLE=3 instances.
module tb_gate_bist;

  localparam logic [3:0] EXP = 4'b1110;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1 = 1'b1, rst3 = 1'b1, start1 = 1'b0, start3 = 1'b0;
  logic y1, y3;
  logic a1, b1, busy1, done1, pass1, a3, b3, busy3, done3, pass3;
  logic [3:0] fv1, fv3;
  logic [2:0] ec1, ec3;
  int gate_sel [2] = '{0, 0};

  int vectors = 0;
  int miscompares = 0;

  gate_bist #(.EXP(EXP), .SETTLE(1)) dut1 (
    .CLK(clk), .RST(rst1), .START(start1), .Y(y1),
    .A(a1), .B(b1), .BUSY(busy1), .DONE(done1), .PASS(pass1),
    .FAIL_VEC(fv1), .ERR_CNT(ec1)
  );

  gate_bist #(.EXP(EXP), .SETTLE(3)) dut3 (
    .CLK(clk), .RST(rst3), .START(start3), .Y(y3),
    .A(a3), .B(b3), .BUSY(busy3), .DONE(done3), .PASS(pass3),
    .FAIL_VEC(fv3), .ERR_CNT(ec3)
  );

  // 0 OR, 1 AND, 2 tied high, 3 tied low, 4 NOR
  function automatic logic gate_out(input int g, input logic a, input logic b);
    case (g)
      0:       return a | b;
      1:       return a & b;
      2:       return 1'b1;
      3:       return 1'b0;
      default: return ~(a | b);
    endcase
  endfunction

  function automatic logic mism(input int g, input int i);
    logic [1:0] iv;
    iv = 2'(i);
    return gate_out(g, iv[1], iv[0]) != EXP[iv];
  endfunction

  always_comb y1 = gate_out(gate_sel[0], a1, b1);
  always_comb y3 = gate_out(gate_sel[1], a3, b3);

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %03h expected %03h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 running since edge t0, 2 finished.
  int cyc = 0;
  int m_mode [2] = '{0, 0};
  int m_t0 [2]   = '{0, 0};
  int m_gate [2] = '{0, 0};
  bit chk_en = 1'b0;

  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      logic r, s;
      int st;
      r  = d ? rst3 : rst1;
      s  = d ? start3 : start1;
      st = d ? 3 : 1;
      if (r) m_mode[d] = 0;
      else if (m_mode[d] != 1 && s) begin
        m_mode[d] = 1;
        m_t0[d]   = cyc;
        m_gate[d] = gate_sel[d];
      end else if (m_mode[d] == 1 && (cyc - m_t0[d]) >= 4 * st) m_mode[d] = 2;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        int k, st;
        logic [1:0] eab;
        logic [3:0] efv;
        logic ebusy, edone, epass;
        logic [2:0] eerr;
        logic [11:0] act;
        st = d ? 3 : 1;
        k = cyc - m_t0[d];
        eab = 2'b00; efv = 4'b0000; ebusy = 1'b0; edone = 1'b0;
        if (m_mode[d] == 1) begin
          ebusy = 1'b1;
          eab = 2'(k / st);
          for (int i = 0; i < 4; i++)
            if ((i + 1) * st <= k && mism(m_gate[d], i)) efv[i] = 1'b1;
        end else if (m_mode[d] == 2) begin
          edone = 1'b1;
          for (int i = 0; i < 4; i++) if (mism(m_gate[d], i)) efv[i] = 1'b1;
        end
        eerr = 3'($countones(efv));
        epass = edone && (efv == 4'b0000);
        act = d ? {a3, b3, busy3, done3, pass3, fv3, ec3} : {a1, b1, busy1, done1, pass1, fv1, ec1};
        chk(d ? "dut3_cycle" : "dut1_cycle", act, {eab, ebusy, edone, epass, efv, eerr});
      end
    end
  end

  // Pulses START on the SETTLE=1 instance and returns cycles from the START edge to DONE.
  task automatic run1(input int g, output int n, output logic [7:0] seq);
    gate_sel[0] = g;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    seq = 8'h00;
    chk("restart_clears", {busy1, done1, pass1, fv1, ec1}, {1'b1, 1'b0, 1'b0, 4'b0000, 3'd0});
    while (!done1 && n < 20) begin
      seq = {seq[5:0], a1, b1};
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    logic [7:0] seq;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_state", {a1, b1, busy1, done1, pass1, fv1, ec1}, 12'h000);
    rst1 = 1'b0;
    rst3 = 1'b0;
    @(negedge clk);

    run1(0, n, seq);
    chk("or_ab_sequence", {4'h0, seq}, {4'h0, 8'b00_01_10_11});
    chk("or_done_cycle", 12'(n), 12'd4);
    chk("or_result", {pass1, fv1, ec1}, {1'b1, 4'b0000, 3'd0});

    run1(1, n, seq);
    chk("and_done_cycle", 12'(n), 12'd4);
    chk("and_result", {pass1, fv1, ec1}, {1'b0, 4'b0110, 3'd2});

    run1(2, n, seq);
    chk("tie1_result", {pass1, fv1, ec1}, {1'b0, 4'b0001, 3'd1});

    run1(3, n, seq);
    chk("tie0_result", {pass1, fv1, ec1}, {1'b0, 4'b1110, 3'd3});

    run1(4, n, seq);
    chk("nor_saturate", {pass1, fv1, ec1}, {1'b0, 4'b1111, 3'd4});

    // Restart from a failing DONE with a good gate.
    run1(0, n, seq);
    chk("rerun_pass", {done1, pass1, fv1, ec1}, {1'b1, 1'b1, 4'b0000, 3'd0});

    // Abort while vector 2 is driven.
    gate_sel[0] = 1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("vec2_driven", {10'h0, a1, b1}, 12'b10);
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    chk("abort_reset", {a1, b1, busy1, done1, pass1, fv1, ec1}, 12'h000);
    run1(0, n, seq);
    chk("post_abort_pass", {done1, pass1, fv1, ec1}, {1'b1, 1'b1, 4'b0000, 3'd0});

    // SETTLE=3 with an ignored START re-pulse at cycle 5.
    gate_sel[1] = 0;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    n = 0;
    while (!done3 && n < 40) begin
      if (n == 4) start3 = 1'b1;
      else start3 = 1'b0;
      @(negedge clk);
      n++;
    end
    start3 = 1'b0;
    chk("settle3_done_cycle", 12'(n), 12'd12);
    chk("settle3_result", {pass3, fv3, ec3}, {1'b1, 4'b0000, 3'd0});

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
